// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
// Integer register file with a writeback scoreboard. Two combinational read
// ports feed the ALU operands. Issue marks the destination register busy, and
// the matching ALU writeback commits the data and clears the busy bit. Busy
// flags on the read side and a WAW stall on the issue side let the issue logic
// hold back on hazards.
//
// Ports:
//   clk, rst                     core clock; asynchronous active-high reset
//   i_rf_rs1_idx / i_rf_rs2_idx  read indices
//   o_rf_rs1 / o_rf_rs2          read data (x0 always reads 0)
//   o_rs1_busy / o_rs2_busy      the register read has an outstanding writer
//   i_iss_vld, i_iss_rd_idx,     issue of an instruction and its destination
//   i_iss_rd_wen
//   o_iss_stall                  WAW: the issued rd is already busy
//   i_wb_wdat, i_wb_rd_idx,      ALU writeback triple
//   i_wb_rd_wen
//   o_wb_err                     sticky: a writeback hit a non-busy register
//
// Optional feature (macro RF_BYPASS_EN): same-cycle writeback forwarding onto
// both read ports. Busy is masked for a register being written back, and the
// WAW stall is masked as well. Without the macro, reads return the stored value
// and a consumer sees the new data one cycle after the writeback.
// -----------------------------------------------------------------------------
module regfile_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_rf_rs1_idx,
  input  logic [AW-1:0]   i_rf_rs2_idx,
  output logic [XLEN-1:0] o_rf_rs1,
  output logic [XLEN-1:0] o_rf_rs2,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  input  logic            i_iss_vld,
  input  logic [AW-1:0]   i_iss_rd_idx,
  input  logic            i_iss_rd_wen,
  output logic            o_iss_stall,
  input  logic [XLEN-1:0] i_wb_wdat,
  input  logic [AW-1:0]   i_wb_rd_idx,
  input  logic            i_wb_rd_wen,
  output logic            o_wb_err
);

  // Entry 0 is reset and never written, so it stays constant zero and
  // synthesis removes it. Reads of x0 are still forced to zero below.
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_wb_err;

  logic            w_wb_hit;
  logic            w_rs1_byp;
  logic            w_rs2_byp;
  logic            w_iss_byp;
  logic            w_iss_stall;
  logic            w_iss_fire;
  logic [NREG-1:0] w_busy_nxt;

  // A writeback to x0 is a no-op: no data, no busy clear, no error.
  assign w_wb_hit = i_wb_rd_wen && (i_wb_rd_idx != '0);

`ifdef RF_BYPASS_EN
  assign w_rs1_byp = w_wb_hit && (i_wb_rd_idx == i_rf_rs1_idx);
  assign w_rs2_byp = w_wb_hit && (i_wb_rd_idx == i_rf_rs2_idx);
  assign w_iss_byp = w_wb_hit && (i_wb_rd_idx == i_iss_rd_idx);
`else
  assign w_rs1_byp = 1'b0;
  assign w_rs2_byp = 1'b0;
  assign w_iss_byp = 1'b0;
`endif

  // Read ports. The busy bit of x0 is never set, so it needs no masking.
  assign o_rf_rs1   = w_rs1_byp ? i_wb_wdat
                    : (i_rf_rs1_idx == '0) ? '0 : r_regs[i_rf_rs1_idx];
  assign o_rf_rs2   = w_rs2_byp ? i_wb_wdat
                    : (i_rf_rs2_idx == '0) ? '0 : r_regs[i_rf_rs2_idx];
  assign o_rs1_busy = r_busy[i_rf_rs1_idx] && !w_rs1_byp;
  assign o_rs2_busy = r_busy[i_rf_rs2_idx] && !w_rs2_byp;

  // The stall looks at the pre-edge busy state. It is masked only when the
  // bypass clears the same rd this cycle.
  assign w_iss_stall = i_iss_vld && i_iss_rd_wen && r_busy[i_iss_rd_idx] && !w_iss_byp;
  assign w_iss_fire  = i_iss_vld && i_iss_rd_wen && (i_iss_rd_idx != '0) && !w_iss_stall;
  assign o_iss_stall = w_iss_stall;
  assign o_wb_err    = r_wb_err;

  // Clear first and set second, so a set and a clear of the same index in
  // one cycle leave the bit set.
  always_comb begin
    // NOTE: assign the default before any conditional update so that no path
    // leaves the signal unassigned and infers a latch.
    w_busy_nxt = r_busy;
    if (w_wb_hit)   w_busy_nxt[i_wb_rd_idx]  = 1'b0;
    if (w_iss_fire) w_busy_nxt[i_iss_rd_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is cleared explicitly because the architecture needs
      // every register to read zero after reset. This costs a reset on each
      // flop, so it is not something to copy into RAM-style storage.
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy   <= '0;
      r_wb_err <= 1'b0;
    end else begin
      if (w_wb_hit) r_regs[i_wb_rd_idx] <= i_wb_wdat;
      r_busy <= w_busy_nxt;
      if (w_wb_hit && !r_busy[i_wb_rd_idx]) r_wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_idx, rs2_idx, iss_rd_idx, wb_rd_idx;
  logic [XLEN-1:0] rf_rs1, rf_rs2, wb_wdat;
  logic            rs1_busy, rs2_busy, iss_vld, iss_rd_wen, iss_stall;
  logic            wb_rd_wen, wb_err;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rf_rs1_idx (rs1_idx),
    .i_rf_rs2_idx (rs2_idx),
    .o_rf_rs1     (rf_rs1),
    .o_rf_rs2     (rf_rs2),
    .o_rs1_busy   (rs1_busy),
    .o_rs2_busy   (rs2_busy),
    .i_iss_vld    (iss_vld),
    .i_iss_rd_idx (iss_rd_idx),
    .i_iss_rd_wen (iss_rd_wen),
    .o_iss_stall  (iss_stall),
    .i_wb_wdat    (wb_wdat),
    .i_wb_rd_idx  (wb_rd_idx),
    .i_wb_rd_wen  (wb_rd_wen),
    .o_wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] idx);
    iss_vld = 1'b1; iss_rd_wen = 1'b1; iss_rd_idx = idx;
  endtask

  task automatic wb(input logic [AW-1:0] idx, input logic [XLEN-1:0] d);
    wb_rd_wen = 1'b1; wb_rd_idx = idx; wb_wdat = d;
  endtask

  task automatic idle();
    iss_vld = 1'b0; iss_rd_wen = 1'b0; iss_rd_idx = '0;
    wb_rd_wen = 1'b0; wb_rd_idx = '0; wb_wdat = '0;
  endtask

  initial begin
    rst = 1'b1;
    rs1_idx = '0; rs2_idx = '0;
    idle();
    #22 rst = 1'b0;
    tick();

    // Reset state on both ports
    for (int i = 0; i < NREG; i++) begin
      rs1_idx = AW'(i); rs2_idx = AW'(NREG - 1 - i);
      #1;
      check($sformatf("rst_rs1_x%0d", i), rf_rs1, 32'h0);
      check($sformatf("rst_rs2_x%0d", i), rf_rs2, 32'h0);
      check($sformatf("rst_b1_x%0d", i), {31'b0, rs1_busy}, 32'h0);
      check($sformatf("rst_b2_x%0d", i), {31'b0, rs2_busy}, 32'h0);
    end
    check("rst_stall", {31'b0, iss_stall}, 32'h0);
    check("rst_err",   {31'b0, wb_err},    32'h0);

    // Issue x5, then write back 0xDEADBEEF
    tick();
    rs1_idx = 5; issue(5);
    #1;
    check("x5_pre_busy",  {31'b0, rs1_busy},  32'h0);
    check("x5_pre_stall", {31'b0, iss_stall}, 32'h0);
    tick();
    idle();
    #1;
    check("x5_busy", {31'b0, rs1_busy}, 32'h1);
    wb(5, 32'hDEADBEEF);
    #1;
`ifdef RF_BYPASS_EN
    check("x5_wb_cyc_data", rf_rs1, 32'hDEADBEEF);
    check("x5_wb_cyc_busy", {31'b0, rs1_busy}, 32'h0);
`else
    check("x5_wb_cyc_data", rf_rs1, 32'h0);
    check("x5_wb_cyc_busy", {31'b0, rs1_busy}, 32'h1);
`endif
    tick();
    idle();
    #1;
    check("x5_data", rf_rs1, 32'hDEADBEEF);
    check("x5_busy_clr", {31'b0, rs1_busy}, 32'h0);
    check("x5_err", {31'b0, wb_err}, 32'h0);

    // WAW stall on x7
    rs2_idx = 7; issue(7);
    tick();
    issue(7);
    #1;
    check("x7_stall", {31'b0, iss_stall}, 32'h1);
    tick();
    idle();
    #1;
    check("x7_still_busy", {31'b0, rs2_busy}, 32'h1);
    wb(7, 32'h12);
    tick();
    idle(); issue(7);
    #1;
    check("x7_data", rf_rs2, 32'h12);
    check("x7_reissue_stall", {31'b0, iss_stall}, 32'h0);
    tick();
    idle();
    #1;
    check("x7_reissue_busy", {31'b0, rs2_busy}, 32'h1);
    wb(7, 32'h34);
    tick();
    idle();
    #1;
    check("x7_data2", rf_rs2, 32'h34);
    check("x7_err", {31'b0, wb_err}, 32'h0);

    // Set and clear of different indices in the same cycle
    issue(11);
    tick();
    idle(); issue(12); wb(11, 32'h0000CAFE);
    tick();
    idle(); rs1_idx = 11; rs2_idx = 12;
    #1;
    check("x11_busy", {31'b0, rs1_busy}, 32'h0);
    check("x12_busy", {31'b0, rs2_busy}, 32'h1);
    check("x11_data", rf_rs1, 32'h0000CAFE);
    wb(12, 32'h0000BEEF);
    tick();
    idle();
    #1;
    check("x12_data", rf_rs2, 32'h0000BEEF);
    check("x12_busy_clr", {31'b0, rs2_busy}, 32'h0);

    // Write to x0 is dropped silently
    wb(0, 32'hFFFFFFFF);
    tick();
    idle(); rs1_idx = 0;
    #1;
    check("x0_data", rf_rs1, 32'h0);
    check("x0_err", {31'b0, wb_err}, 32'h0);

    // Writeback to a non-busy register sets the sticky error
    wb(9, 32'h1); rs1_idx = 9;
    #1;
    check("x9_err_pre", {31'b0, wb_err}, 32'h0);
    tick();
    idle();
    #1;
    check("x9_err", {31'b0, wb_err}, 32'h1);
    check("x9_data", rf_rs1, 32'h1);
    tick();
    check("x9_err_sticky", {31'b0, wb_err}, 32'h1);

    // x3: writeback, read and re-issue in the same cycle
    issue(3);
    tick();
    idle(); rs2_idx = 3; wb(3, 32'hA5A5A5A5); issue(3);
    #1;
`ifdef RF_BYPASS_EN
    check("x3_byp_data",  rf_rs2, 32'hA5A5A5A5);
    check("x3_byp_busy",  {31'b0, rs2_busy},  32'h0);
    check("x3_byp_stall", {31'b0, iss_stall}, 32'h0);
`else
    check("x3_byp_data",  rf_rs2, 32'h0);
    check("x3_byp_busy",  {31'b0, rs2_busy},  32'h1);
    check("x3_byp_stall", {31'b0, iss_stall}, 32'h1);
`endif
    tick();
    idle();
    #1;
    check("x3_data", rf_rs2, 32'hA5A5A5A5);
`ifdef RF_BYPASS_EN
    check("x3_set_wins", {31'b0, rs2_busy}, 32'h1);
    wb(3, 32'hA5A5A5A5);
    tick();
    idle();
`else
    check("x3_set_wins", {31'b0, rs2_busy}, 32'h0);
`endif

    // Asynchronous reset while x4 is busy and holds 0x55
    rs1_idx = 4; issue(4);
    tick();
    idle(); wb(4, 32'h55);
    tick();
    idle(); issue(4);
    tick();
    idle();
    #1;
    check("x4_pre_data", rf_rs1, 32'h55);
    check("x4_pre_busy", {31'b0, rs1_busy}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("x4_rst_data", rf_rs1, 32'h0);
    check("x4_rst_busy", {31'b0, rs1_busy}, 32'h0);
    check("x4_rst_err",  {31'b0, wb_err},   32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wb(4, 32'h77);
    tick();
    idle();
    #1;
    check("x4_post_err",  {31'b0, wb_err}, 32'h1);
    check("x4_post_data", rf_rs1, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Integer register file and writeback scoreboard for the core.
- Sources the operand buses that feed the ALU.
- Sinks the ALU's writeback triple (write data, rd index, rd write enable).
- Issue marks the destination register pending; the matching writeback commits the data and clears the pending bit. Read-side busy flags let issue logic stall on RAW and WAW hazards.

Parameters:
- XLEN, 32, data width of each register and of the read/write data buses
- NREG, 32, number of architectural registers; index 0 is hardwired zero
- AW, 5, register index width; must equal clog2(NREG)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- i_rf_rs1_idx  input  AW  read port 1 index
- i_rf_rs2_idx  input  AW  read port 2 index
- o_rf_rs1  output  XLEN  read port 1 data, goes to the ALU rs1 operand
- o_rf_rs2  output  XLEN  read port 2 data, goes to the ALU rs2 operand
- o_rs1_busy  output  1  rs1 register has an outstanding writer
- o_rs2_busy  output  1  rs2 register has an outstanding writer
- i_iss_vld  input  1  instruction issued this cycle
- i_iss_rd_idx  input  AW  destination index of the issued instruction
- i_iss_rd_wen  input  1  issued instruction writes rd
- o_iss_stall  output  1  issue must not proceed (WAW: rd already busy)
- i_wb_wdat  input  XLEN  writeback data from the ALU
- i_wb_rd_idx  input  AW  writeback destination from the ALU
- i_wb_rd_wen  input  1  writeback enable from the ALU
- o_wb_err  output  1  sticky flag: writeback hit a non-busy register

Behaviour:
- Clock and reset: single clock domain, clk. rst is asynchronous and active-high.
- Reset:
  - All NREG registers clear to 0.
  - All busy bits clear to 0.
  - o_wb_err clears to 0.
  - Reset asserted mid-operation discards pending writers. A writeback arriving in the first cycle after reset deassertion raises o_wb_err (see Error flag).
- Reads:
  - Combinational, zero latency.
  - o_rf_rsN = reg[idx]; index 0 always returns 0.
  - o_rsN_busy = busy[idx]; busy[0] is always 0.
- Writes:
  - On rising clk, when i_wb_rd_wen=1 and i_wb_rd_idx!=0: reg[i_wb_rd_idx] <= i_wb_wdat.
  - Writes to index 0 are silently dropped and cause no error.
  - Full XLEN write; no partial writes.
- Issue (set):
  - Define iss_fire = i_iss_vld & i_iss_rd_wen & (i_iss_rd_idx!=0) & ~o_iss_stall.
  - On iss_fire, busy[i_iss_rd_idx] <= 1.
- Issue stall:
  - o_iss_stall = i_iss_vld & i_iss_rd_wen & busy[i_iss_rd_idx].
  - Combinational; no stall for index 0.
- Writeback (clear): on rising clk, when i_wb_rd_wen=1 and idx!=0, busy[i_wb_rd_idx] <= 0.
- Simultaneous set and clear, same index, same cycle:
  - Set wins; the busy bit ends at 1.
  - o_iss_stall is evaluated on pre-edge state, so this case only happens when the bypass (see Optional Feature) masks the busy bit.
  - Without the bypass this case cannot occur.
- Simultaneous set and clear, different indices: both take effect.
- Error flag: a writeback with wen=1, idx!=0 and busy[idx]=0 sets o_wb_err <= 1. The flag holds until rst.
- No internal FSM beyond the busy vector. Total state is NREG-1 data registers, NREG-1 busy bits and 1 error bit.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Same-cycle writeback forwarding on both read ports. If i_wb_rd_wen=1, i_wb_rd_idx!=0 and i_wb_rd_idx==i_rf_rsN_idx, then o_rf_rsN = i_wb_wdat and o_rsN_busy = 0.
  - o_iss_stall is also masked when the writeback clears the same rd that same cycle; the set then wins per the simultaneous set/clear rule.
  - Operand read latency after writeback is 0 cycles.
- Undefined:
  - Reads return the stored value.
  - Busy reflects the pre-edge state.
  - A consumer sees the new value and busy=0 one cycle after writeback.

Test Plan:
- Reset, then read x0..x31 on both ports -> all data 0, all busy 0, o_iss_stall 0, o_wb_err 0.
- Issue rd=5, then next cycle writeback x5=0xDEADBEEF -> o_rs1_busy=1 in the cycle between issue and writeback; the cycle after writeback, rs1_idx=5 gives 0xDEADBEEF with busy=0.
- Issue rd=7, then issue rd=7 again before writeback -> o_iss_stall=1 and busy[7] unchanged; after writeback x7=0x12, re-issue succeeds with stall=0.
- Writeback idx=0 data 0xFFFFFFFF, then read x0 -> 0 and o_wb_err stays 0. Writeback x9=1 with busy[9]=0 -> o_wb_err=1 on the next cycle and it stays set.
- RF_BYPASS_EN defined: busy x3, then writeback x3=0xA5A5A5A5 with rs2_idx=3 in the same cycle -> o_rf_rs2=0xA5A5A5A5 and o_rs2_busy=0 in that cycle. With the macro undefined -> old value and busy=1 in that cycle.
- Assert rst asynchronously mid-cycle while x4 is busy and holds 0x55 -> busy and data clear immediately, without waiting for a clk edge. A writeback to x4 after reset deassertion -> o_wb_err=1.
